// File: rtl/atm_account_arbiter_pkg.sv
// Shared encodings for the ATM account arbiter: op codes, FSM states, ledger defaults.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_WDRAW  = 2'b00,
    OP_DEP    = 2'b01,
    OP_INQ    = 2'b10,
    OP_PINCHG = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    EXEC  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam int DEF_INIT_BAL = 800;
  localparam int DEF_INIT_PIN = 1211;

endpackage

// File: rtl/atm_account_arbiter_rr_arbiter.sv
// Purpose: N-way round-robin pick, first asserted req at or after ptr (wrapping).
// Latency: purely combinational, no state.
// Backpressure: none; requesters hold req until granted, the parent owns ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!vld && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// Purpose: round-robin sequencer sharing one balance/PIN ledger among N_TERM terminals (lockout via ATM_ARB_LOCKOUT_EN).
// Latency: fixed 3 cycles from req sample to single-cycle done; one transaction per 4 cycles.
// Backpressure: terminals hold req/payload until gnt; requests are ignored while busy.
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int N_TERM   = 4,
  parameter int WIDTH    = 17,
  parameter int INIT_BAL = DEF_INIT_BAL,
  parameter int INIT_PIN = DEF_INIT_PIN
`ifdef ATM_ARB_LOCKOUT_EN
  ,
  parameter int MAX_TRIES = 3
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_TERM-1:0]          req,
  input  logic [2*N_TERM-1:0]        op,
  input  logic [WIDTH*N_TERM-1:0]    pin,
  input  logic [WIDTH*N_TERM-1:0]    arg,
  output logic [N_TERM-1:0]          gnt,
  output logic                       done,
  output logic                       ok,
  output logic                       err,
  output logic [$clog2(N_TERM)-1:0]  rsp_id,
  output logic [WIDTH-1:0]           balance,
  output logic                       busy,
  output logic                       locked
);

  localparam int IW = $clog2(N_TERM);

  typedef struct packed {
    op_t              op;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] arg;
  } txn_t;

  state_t             state, state_nxt;
  txn_t               txn;
  logic [IW-1:0]      ptr, win_id, arb_idx;
  logic [N_TERM-1:0]  arb_gnt, gnt_q;
  logic               arb_vld;
  logic [WIDTH-1:0]   led_bal, led_pin;
  logic               pin_ok, res_ok;
  logic               exec_ok;
  logic [WIDTH-1:0]   bal_nxt, pin_nxt;
  logic [WIDTH:0]     dep_sum;
  logic               locked_q;

  rr_arbiter #(.N(N_TERM), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (arb_vld) state_nxt = CHECK;
      end
      CHECK:   state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ledger effect of the latched op; the ledger is left untouched on any rejection.
  always_comb begin
    dep_sum = {1'b0, led_bal} + {1'b0, txn.arg};
    exec_ok = 1'b0;
    bal_nxt = led_bal;
    pin_nxt = led_pin;
    if (!locked_q && pin_ok) begin
      case (txn.op)
        OP_WDRAW: if (txn.arg <= led_bal) begin
          bal_nxt = led_bal - txn.arg;
          exec_ok = 1'b1;
        end
        OP_DEP: if (!dep_sum[WIDTH]) begin
          bal_nxt = dep_sum[WIDTH-1:0];
          exec_ok = 1'b1;
        end
        OP_INQ: exec_ok = 1'b1;
        OP_PINCHG: if (txn.arg != '0) begin
          pin_nxt = txn.arg;
          exec_ok = 1'b1;
        end
        default: exec_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn     <= '0;
      gnt_q   <= '0;
      win_id  <= '0;
      ptr     <= '0;
      pin_ok  <= 1'b0;
      res_ok  <= 1'b0;
      led_bal <= WIDTH'(INIT_BAL);
      led_pin <= WIDTH'(INIT_PIN);
      balance <= '0;
    end else begin
      case (state)
        IDLE: if (arb_vld) begin
          txn <= '{op:  op_t'(op[2*arb_idx +: 2]),
                   pin: pin[WIDTH*arb_idx +: WIDTH],
                   arg: arg[WIDTH*arb_idx +: WIDTH]};
          gnt_q  <= arb_gnt;
          win_id <= arb_idx;
        end
        CHECK: pin_ok <= (txn.pin == led_pin);
        EXEC: begin
          res_ok  <= exec_ok;
          led_bal <= bal_nxt;
          led_pin <= pin_nxt;
          if (exec_ok) balance <= bal_nxt;
        end
        RESP: begin
          gnt_q <= '0;
          ptr   <= (win_id == IW'(N_TERM - 1)) ? '0 : win_id + 1'b1;
        end
        default: gnt_q <= '0;
      endcase
    end
  end

`ifdef ATM_ARB_LOCKOUT_EN
  localparam int FW = $clog2(MAX_TRIES + 1);
  logic [FW-1:0] fail_cnt;

  // Lock is raised at the edge into RESP, so it is visible with the failing response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt <= '0;
      locked_q <= 1'b0;
    end else if (state == EXEC) begin
      if (pin_ok) begin
        fail_cnt <= '0;
      end else begin
        if (int'(fail_cnt) < MAX_TRIES) fail_cnt <= fail_cnt + 1'b1;
        if (int'(fail_cnt) + 1 >= MAX_TRIES) locked_q <= 1'b1;
      end
    end
  end
`else
  assign locked_q = 1'b0;
`endif

  assign gnt    = gnt_q;
  assign ok     = done & res_ok;
  assign err    = done & ~res_ok;
  assign rsp_id = done ? win_id : '0;
  assign locked = locked_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed plus random checks of atm_account_arbiter against a ledger model built from the op rules.
module tb_atm_account_arbiter;
  import atm_pkg::*;

  localparam int     N    = 4;
  localparam int     W    = 17;
  localparam int     IW   = 2;
  localparam longint MAXV = (longint'(1) << W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [W*N-1:0] pin, arg;
  logic [N-1:0]   gnt;
  logic           done, ok, err, busy, locked;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   balance;

  int errors = 0;
  int checks = 0;

  longint m_bal, m_pin, m_out;
  int     m_ptr, m_fail;
  bit     m_locked;

  always #5 clk = ~clk;

  atm_account_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op      (op),
    .pin     (pin),
    .arg     (arg),
    .gnt     (gnt),
    .done    (done),
    .ok      (ok),
    .err     (err),
    .rsp_id  (rsp_id),
    .balance (balance),
    .busy    (busy),
    .locked  (locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction

  function automatic bit model_txn(input int o, input longint p, input longint a);
    bit good;
    bit match;
    good  = 1'b0;
    match = (p == m_pin);
    if (!m_locked && match) begin
      case (o)
        0: if (a <= m_bal) begin m_bal = m_bal - a; good = 1'b1; end
        1: if (m_bal + a <= MAXV) begin m_bal = m_bal + a; good = 1'b1; end
        2: good = 1'b1;
        default: if (a != 0) begin m_pin = a; good = 1'b1; end
      endcase
    end
`ifdef ATM_ARB_LOCKOUT_EN
    if (match) m_fail = 0;
    else begin
      m_fail++;
      if (m_fail >= 3) m_locked = 1'b1;
    end
`endif
    if (good) m_out = m_bal;
    return good;
  endfunction

  task automatic model_init();
    m_bal = 800; m_pin = 1211; m_out = 0;
    m_ptr = 0; m_fail = 0; m_locked = 1'b0;
  endtask

  task automatic set_term(input int i, input logic [1:0] o, input int p, input int a);
    op[2*i +: 2]  = o;
    pin[W*i +: W] = W'(p);
    arg[W*i +: W] = W'(a);
    req[i]        = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; op = '0; pin = '0; arg = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_init();
  endtask

  // One full transaction from the current req vector; entered and left #1 after an edge in IDLE.
  task automatic serve(input string tag);
    int           w;
    bit           exp_ok;
    logic [N-1:0] g;
    w      = pick(req);
    exp_ok = model_txn(int'(op[2*w +: 2]), longint'(pin[W*w +: W]), longint'(arg[W*w +: W]));
    g      = '0;
    g[w]   = 1'b1;
    @(posedge clk); #1;
    check({tag, " gnt"}, 32'(gnt), 32'(g));
    check({tag, " busy"}, 32'(busy), 1);
    check({tag, " early_done"}, 32'(done), 0);
    req[w]        = 1'b0;
    pin[W*w +: W] = W'($urandom);
    arg[W*w +: W] = W'($urandom);
    @(posedge clk); #1;
    check({tag, " mid_done"}, 32'(done), 0);
    @(posedge clk); #1;
    check({tag, " done"}, 32'(done), 1);
    check({tag, " ok"}, 32'(ok), 32'(exp_ok));
    check({tag, " err"}, 32'(err), 32'(!exp_ok));
    check({tag, " rsp_id"}, 32'(rsp_id), 32'(w));
    check({tag, " balance"}, 32'(balance), 32'(m_out));
    check({tag, " gnt_hold"}, 32'(gnt), 32'(g));
    check({tag, " locked"}, 32'(locked), 32'(m_locked));
    m_ptr = (w + 1) % N;
    @(posedge clk); #1;
    check({tag, " post_done"}, 32'(done), 0);
    check({tag, " post_gnt"}, 32'(gnt), 0);
    check({tag, " post_busy"}, 32'(busy), 0);
    check({tag, " post_ok"}, 32'(ok), 0);
  endtask

  // Reset lands while the transaction sits in EXEC: it must vanish without a done.
  task automatic mid_reset(input string tag);
    set_term(0, OP_DEP, int'(m_pin), 50);
    @(posedge clk); #1;
    req = '0;
    check({tag, " gnt"}, 32'(gnt), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check({tag, " gnt_clr"}, 32'(gnt), 0);
    check({tag, " busy_clr"}, 32'(busy), 0);
    check({tag, " locked_clr"}, 32'(locked), 0);
    check({tag, " bal_clr"}, 32'(balance), 0);
    @(posedge clk); #1;
    check({tag, " no_done"}, 32'(done), 0);
    rst = 1'b0;
    model_init();
    @(posedge clk); #1;
    check({tag, " still_no_done"}, 32'(done), 0);
    set_term(1, OP_INQ, 1211, 0);
    serve({tag, " inq"});
    check({tag, " bal_init"}, 32'(balance), 800);
  endtask

  task automatic rand_term(input int i);
    int o, p, a;
    o = int'($urandom_range(3, 0));
    p = ($urandom_range(7, 0) == 0) ? int'($urandom_range(9999, 0)) : int'(m_pin);
    case (o)
      0:       a = int'($urandom_range(900, 0));
      1:       a = ($urandom_range(4, 0) == 0) ? int'($urandom_range(131071, 130000))
                                                : int'($urandom_range(600, 0));
      2:       a = int'($urandom_range(9999, 0));
      default: a = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(9999, 1));
    endcase
    set_term(i, 2'(o), p, a);
  endtask

  initial begin
    rst = 1'b1;
    req = '0; op = '0; pin = '0; arg = '0;
    model_init();
    repeat (2) @(posedge clk);
    #1;
    check("rst gnt", 32'(gnt), 0);
    check("rst done", 32'(done), 0);
    check("rst ok", 32'(ok), 0);
    check("rst err", 32'(err), 0);
    check("rst rsp_id", 32'(rsp_id), 0);
    check("rst balance", 32'(balance), 0);
    check("rst busy", 32'(busy), 0);
    check("rst locked", 32'(locked), 0);
    rst = 1'b0;

    set_term(0, OP_WDRAW, 1211, 300);
    serve("wd300");
    check("wd300 bal", 32'(balance), 500);

    do_reset();
    set_term(1, OP_DEP, 1211, 100);
    set_term(3, OP_DEP, 1211, 100);
    serve("dep_t1");
    check("dep_t1 bal", 32'(balance), 900);
    serve("dep_t3");
    check("dep_t3 bal", 32'(balance), 1000);
    check("dep_t3 id", 32'(rsp_id), 0);

    do_reset();
    set_term(2, OP_WDRAW, 1211, 801);
    serve("wd801");
    set_term(2, OP_INQ, 1211, 0);
    serve("inq800");
    check("inq800 bal", 32'(balance), 800);

    set_term(1, OP_DEP, 1211, 130271);
    serve("dep_max");
    check("dep_max bal", 32'(balance), 131071);
    set_term(0, OP_DEP, 1211, 1);
    serve("dep_ovf");
    set_term(3, OP_INQ, 1211, 0);
    serve("inq_max");
    check("inq_max bal", 32'(balance), 131071);

    do_reset();
    set_term(0, OP_PINCHG, 1211, 4242);
    serve("pinchg");
    set_term(1, OP_WDRAW, 1211, 10);
    serve("old_pin");
    set_term(2, OP_WDRAW, 4242, 10);
    serve("new_pin");
    check("new_pin bal", 32'(balance), 790);
    set_term(3, OP_PINCHG, 4242, 0);
    serve("pin_zero");

`ifdef ATM_ARB_LOCKOUT_EN
    do_reset();
    for (int t = 0; t < 3; t++) begin
      set_term(2, OP_WDRAW, 1, 5);
      serve("bad_pin");
    end
    check("lock set", 32'(locked), 1);
    set_term(2, OP_INQ, 1211, 0);
    serve("locked_inq");
`endif

    do_reset();
    mid_reset("mid_rst");

    do_reset();
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(1, 0) == 1) rand_term(i);
      if (req == '0) rand_term(int'($urandom_range(N - 1, 0)));
      serve("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atm_account_arbiter.md
# atm_account_arbiter

Round-robin arbiter and transaction sequencer that shares one account ledger (balance and PIN) between `N_TERM` ATM terminals. It grants one terminal at a time and latches that terminal's request. It then checks the PIN, performs one withdraw, deposit, inquiry or PIN-change operation against the shared ledger, and returns a single-cycle response tagged with the terminal index. The block sits between the terminal front-ends and the ledger registers, which it owns.

## Interface
- `N_TERM`, 4: number of requesting terminals (2..8).
- `WIDTH`, 17: width of PIN, amount and balance.
- `INIT_BAL`, 800: ledger balance after reset.
- `INIT_PIN`, 1211: ledger PIN after reset.
- `MAX_TRIES`, 3: consecutive PIN failures before lockout (lockout build only).

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  N_TERM  per-terminal request.
- `op`  in  2*N_TERM  per-terminal mode: 00 withdraw, 01 deposit, 10 inquiry, 11 PIN change.
- `pin`  in  WIDTH*N_TERM  per-terminal entered PIN.
- `arg`  in  WIDTH*N_TERM  per-terminal amount, or the new PIN for op 11.
- `gnt`  out  N_TERM  one-hot grant, held from latch until response.
- `done`  out  1  response-valid pulse.
- `ok`  out  1  transaction succeeded; valid with `done`.
- `err`  out  1  transaction rejected; valid with `done`.
- `rsp_id`  out  $clog2(N_TERM)  terminal index of the response.
- `balance`  out  WIDTH  ledger balance reported by the last successful transaction.
- `busy`  out  1  high whenever the state is not IDLE.
- `locked`  out  1  account locked.

## Operation
- FSM states: IDLE, CHECK, EXEC, RESP.
- IDLE: if any `req` is high, select a winner round-robin starting at `ptr`. Latch the winner's `op`/`pin`/`arg`, set its `gnt` bit, and go to CHECK.
- CHECK: `pin_ok` = latched pin == ledger PIN, computed as a full WIDTH compare. Go to EXEC.
- EXEC: if `locked` or !`pin_ok`, the result is err. Otherwise:
  - 00: if arg <= bal, then bal -= arg and ok; else err, bal unchanged.
  - 01: compute a WIDTH+1-bit sum. If the carry is set, err and bal unchanged; else bal = sum and ok.
  - 10: ok, bal unchanged.
  - 11: if arg == 0, err; else ledger PIN = arg and ok.
  - Go to RESP.
- RESP: pulse `done` with `ok`/`err` (exactly one high) and `rsp_id`.
  - On ok, `balance` takes the post-op bal for all ops, including op 11.
  - Clear `gnt`, set `ptr` = winner+1 mod N_TERM, and go to IDLE.
- Handshake: a terminal holds `req` and its payload until `gnt`. The payload is ignored after the latch.
  - Dropping `req` while granted does not abort the transaction; `done` still pulses.
  - A `req` still high when the FSM returns to IDLE counts as a new request at lowest priority.
- Reset values:
  - Outputs: `gnt`=0, `done`=`ok`=`err`=0, `rsp_id`=0, `balance`=0, `busy`=0, `locked`=0.
  - Internal: `ptr`=0, ledger bal=INIT_BAL, ledger PIN=INIT_PIN, fail count=0.
- Reset asserted mid-transaction discards the transaction immediately. No `done` is issued and the ledger returns to its init values.

## Timing
- If IDLE samples `req` at edge T: `gnt` is high from T+1 through T+3, `done` is high for the single cycle after edge T+3, and IDLE is re-entered at T+4.
- Fixed 3-cycle request-to-response latency for every op and every outcome.
- Next grant occurs at T+4 at the earliest; with all terminals requesting, throughput is one transaction per 4 cycles.
- `ok`, `err` and `rsp_id` are meaningful only while `done` is high, and are 0 otherwise.
- `balance` changes only in the cycle `done` rises with ok.

## Configuration
- Macro `ATM_ARB_LOCKOUT_EN`.
- Defined:
  - A fail counter increments on each pin mismatch in EXEC and clears on a match.
  - When it reaches MAX_TRIES, `locked` goes high at the RESP of that transaction and stays high until `rst`.
  - While locked, every transaction returns err.
- Undefined: no counter is built, `locked` is tied to 0, and pin mismatches still return err.

## Structure
- Package `atm_pkg`:
  - Op encodings `OP_WDRAW`, `OP_DEP`, `OP_INQ`, `OP_PINCHG`.
  - FSM state typedef.
  - Default `INIT_BAL`/`INIT_PIN` constants.
- Sub-module `rr_arbiter`: N-way round-robin with `req`, `ptr` in, one-hot `gnt` and index out. Purely combinational; the pointer register stays in the parent.

## Test plan
- Reset, then terminal 0 withdraws 300 with PIN 1211 → `done` 3 cycles after the `req` sample; ok=1, rsp_id=0, balance=500.
- Terminals 1 and 3 request together, deposit 100 each, `ptr`=0 → terminal 1 is served first (balance 900), then terminal 3 (balance 1000, rsp_id=3).
- Withdraw 801 from the 800 init balance → err=1; a following inquiry returns ok with balance=800.
- Deposit 1 with bal=131071 → err=1 (overflow) and the ledger is unchanged.
- PIN change to 4242, then withdraw with 1211 → err. Withdraw with 4242 → ok.
- `ATM_ARB_LOCKOUT_EN` build: three wrong PINs → `locked`=1. A correct-PIN inquiry then returns err. `rst` mid-EXEC clears `locked`, `gnt`, and resets bal to 800 with no `done`.
